// File: rtl/toivoh_basilisc_2816.sv
// 16-bit accumulator CPU for Tiny Tapeout. Code and data live off-chip and are
// reached through 4-cycle byte-serial transactions (addr lo, addr hi, data lo, data hi) on uio.
module toivoh_basilisc_2816 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_DATA  = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  typedef enum logic [3:0] {
    OP_LDI  = 4'h0, OP_LD  = 4'h1, OP_ST  = 4'h2, OP_ADD = 4'h3,
    OP_SUB  = 4'h4, OP_AND = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7,
    OP_JMP  = 4'h8, OP_JZ  = 4'h9, OP_JC  = 4'hA, OP_SHL = 4'hB,
    OP_SHR  = 4'hC, OP_LDH = 4'hD, OP_NOP = 4'hE, OP_HALT = 4'hF
  } op_e;

  state_e      state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [15:0] pc_q, a_q, ir_q;
  logic        c_q;
  logic [7:0]  rd_lo_q;

  logic        stall;
  op_e         op;
  logic [15:0] imm16;
  logic [15:0] rd_word;
  logic        is_mem_op;
  logic        in_txn;
  logic        is_write;
  logic [15:0] bus_addr;

  logic [15:0] pc_next, a_exec, a_data;
  logic        c_exec, c_data;
  logic [16:0] sum17;

  logic        unused_ok;
  assign unused_ok = &{1'b0, ena, ui_in[7:1]};

  assign stall     = ui_in[0];
  assign op        = op_e'(ir_q[15:12]);
  assign imm16     = {4'h0, ir_q[11:0]};
  assign rd_word   = {uio_in, rd_lo_q};
  assign is_mem_op = (ir_q[15:12] >= 4'h1) && (ir_q[15:12] <= 4'h7);
  assign in_txn    = (state_q == S_FETCH) || (state_q == S_DATA);
  assign is_write  = (state_q == S_DATA) && (op == OP_ST);
  assign bus_addr  = (state_q == S_FETCH) ? pc_q : imm16;

  // State register; stall freezes everything, including mid-transaction phase.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so all registers update from pre-edge values.
    if (!rst_n) begin
      state_q <= S_FETCH;
      phase_q <= 2'd0;
    end else if (!stall) begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    phase_d = phase_q;
    unique case (state_q)
      S_FETCH: begin
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd3) state_d = S_EXEC;
      end
      S_DATA: begin
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd3) state_d = S_FETCH;
      end
      S_EXEC: begin
        phase_d = 2'd0;
        if (op == OP_HALT)  state_d = S_HALT;
        else if (is_mem_op) state_d = S_DATA;
        else                state_d = S_FETCH;
      end
      default: ;
    endcase
  end

  // Register-only results of the EXEC cycle.
  always_comb begin
    pc_next = pc_q + 16'd1;
    a_exec  = a_q;
    c_exec  = c_q;
    unique case (op)
      OP_LDI: a_exec = imm16;
      OP_JMP: pc_next = imm16;
      OP_JZ:  if (a_q == 16'd0) pc_next = imm16;
      OP_JC:  if (c_q) pc_next = imm16;
      OP_SHL: begin
        a_exec = {a_q[14:0], 1'b0};
        c_exec = a_q[15];
      end
      OP_SHR: begin
        a_exec = {1'b0, a_q[15:1]};
        c_exec = a_q[0];
      end
      OP_LDH: a_exec = {ir_q[7:0], a_q[7:0]};
      default: ;
    endcase
  end

  // Memory-operand results, applied at the edge ending DATA T3.
  always_comb begin
    a_data = a_q;
    c_data = c_q;
    sum17  = {1'b0, a_q} + {1'b0, rd_word};
    unique case (op)
      OP_LD:  a_data = rd_word;
      OP_ADD: {c_data, a_data} = sum17;
      OP_SUB: begin
        a_data = a_q - rd_word;
        c_data = a_q < rd_word;
      end
      OP_AND: a_data = a_q & rd_word;
      OP_OR:  a_data = a_q | rd_word;
      OP_XOR: a_data = a_q ^ rd_word;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= 16'd0;
      a_q     <= 16'd0;
      c_q     <= 1'b0;
      ir_q    <= 16'd0;
      rd_lo_q <= 8'd0;
    end else if (!stall) begin
      unique case (state_q)
        S_FETCH: begin
          if (phase_q == 2'd2) rd_lo_q <= uio_in;
          if (phase_q == 2'd3) ir_q <= rd_word;
        end
        S_EXEC: begin
          pc_q <= pc_next;
          a_q  <= a_exec;
          c_q  <= c_exec;
        end
        S_DATA: begin
          if (phase_q == 2'd2) rd_lo_q <= uio_in;
          if (phase_q == 2'd3) begin
            a_q <= a_data;
            c_q <= c_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode registered state only.
  always_comb begin
    uo_out  = {state_q == S_FETCH, a_q == 16'd0, c_q, state_q == S_HALT,
               in_txn ? phase_q : 2'd0, is_write, in_txn && (phase_q == 2'd0)};
    uio_out = 8'h00;
    uio_oe  = 8'h00;
    if (in_txn) begin
      unique case (phase_q)
        2'd0: uio_out = bus_addr[7:0];
        2'd1: uio_out = bus_addr[15:8];
        2'd2: if (is_write) uio_out = a_q[7:0];
        2'd3: if (is_write) uio_out = a_q[15:8];
        default: ;
      endcase
      if (phase_q < 2'd2 || is_write) uio_oe = 8'hFF;
    end
  end

endmodule

// File: tb/tb_toivoh_basilisc_2816.sv
// Bench for toivoh_basilisc_2816: acts as the external memory and runs an
// instruction-level model of the ISA, checking every bus cycle it predicts.
module tb_toivoh_basilisc_2816;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  toivoh_basilisc_2816 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [0:65535];
  logic [15:0] m_pc, m_a;
  logic        m_c, m_halted;
  int          vectors    = 0;
  int          miscompares = 0;
  int          stall_pct  = 10;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] uo(input logic fetch, input logic wr, input logic [1:0] ph,
                                    input logic start, input logic halt);
    return {fetch, m_a == 16'd0, m_c, halt, ph, wr, start};
  endfunction

  // One bus cycle: drive read byte, check outputs, optionally stall a few
  // cycles with garbage on uio_in, then advance one clock.
  task automatic cyc(input string tag, input logic [7:0] e_uo, input logic [7:0] e_out,
                     input logic [7:0] e_oe, input logic [7:0] rd);
    uio_in = rd;
    check({tag, ".uo"}, {8'h0, uo_out}, {8'h0, e_uo});
    check({tag, ".out"}, {8'h0, uio_out}, {8'h0, e_out});
    check({tag, ".oe"}, {8'h0, uio_oe}, {8'h0, e_oe});
    if ($urandom_range(99, 0) < stall_pct) begin
      ui_in[0] = 1'b1;
      repeat ($urandom_range(3, 1)) begin
        uio_in = 8'($urandom);
        @(posedge clk); #1;
        check({tag, ".stall.uo"}, {8'h0, uo_out}, {8'h0, e_uo});
        check({tag, ".stall.out"}, {8'h0, uio_out}, {8'h0, e_out});
        check({tag, ".stall.oe"}, {8'h0, uio_oe}, {8'h0, e_oe});
      end
      ui_in[0] = 1'b0;
      uio_in = rd;
    end
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    m_pc = 16'd0;
    m_a = 16'd0;
    m_c = 1'b0;
    m_halted = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ui_in = 8'h00;
    #1;
    check("rst.uo", {8'h0, uo_out}, 16'h00C1);
    check("rst.oe", {8'h0, uio_oe}, 16'h00FF);
    check("rst.out", {8'h0, uio_out}, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    model_reset();
  endtask

  // Executes one instruction at the model PC; abort_d1 stops once DATA T1 is reached.
  task automatic run_instr(input bit abort_d1);
    logic [15:0] w, imm, d, nxt;
    logic [16:0] s;
    logic [3:0]  op;
    logic        wr;
    w   = mem[m_pc];
    op  = w[15:12];
    imm = {4'h0, w[11:0]};
    cyc("f0", uo(1, 0, 2'd0, 1, 0), m_pc[7:0], 8'hFF, 8'($urandom));
    cyc("f1", uo(1, 0, 2'd1, 0, 0), m_pc[15:8], 8'hFF, 8'($urandom));
    cyc("f2", uo(1, 0, 2'd2, 0, 0), 8'h00, 8'h00, w[7:0]);
    cyc("f3", uo(1, 0, 2'd3, 0, 0), 8'h00, 8'h00, w[15:8]);
    cyc("ex", uo(0, 0, 2'd0, 0, 0), 8'h00, 8'h00, 8'($urandom));
    nxt = m_pc + 16'd1;
    case (op)
      4'h0: m_a = imm;
      4'h8: nxt = imm;
      4'h9: if (m_a == 16'd0) nxt = imm;
      4'hA: if (m_c) nxt = imm;
      4'hB: begin m_c = m_a[15]; m_a = m_a << 1; end
      4'hC: begin m_c = m_a[0];  m_a = m_a >> 1; end
      4'hD: m_a = {w[7:0], m_a[7:0]};
      4'hF: m_halted = 1'b1;
      default: ;
    endcase
    m_pc = nxt;
    if (op >= 4'h1 && op <= 4'h7) begin
      wr = (op == 4'h2);
      d  = mem[imm];
      cyc("d0", uo(0, wr, 2'd0, 1, 0), imm[7:0], 8'hFF, 8'($urandom));
      if (abort_d1) return;
      cyc("d1", uo(0, wr, 2'd1, 0, 0), imm[15:8], 8'hFF, 8'($urandom));
      cyc("d2", uo(0, wr, 2'd2, 0, 0), wr ? m_a[7:0] : 8'h00, wr ? 8'hFF : 8'h00,
          wr ? 8'($urandom) : d[7:0]);
      cyc("d3", uo(0, wr, 2'd3, 0, 0), wr ? m_a[15:8] : 8'h00, wr ? 8'hFF : 8'h00,
          wr ? 8'($urandom) : d[15:8]);
      case (op)
        4'h1: m_a = d;
        4'h2: mem[imm] = m_a;
        4'h3: begin s = m_a + d; m_a = s[15:0]; m_c = s[16]; end
        4'h4: begin m_c = m_a < d; m_a = m_a - d; end
        4'h5: m_a = m_a & d;
        4'h6: m_a = m_a | d;
        4'h7: m_a = m_a ^ d;
        default: ;
      endcase
    end
  endtask

  task automatic run_prog(input int max_instr);
    for (int i = 0; i < max_instr && !m_halted; i++) run_instr(1'b0);
    if (m_halted)
      for (int k = 0; k < 3; k++) cyc("halt", uo(0, 0, 2'd0, 0, 1), 8'h00, 8'h00, 8'($urandom));
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 16'hE000;
  endtask

  task automatic random_mem();
    logic [15:0] w;
    for (int i = 0; i < 8192; i++) begin
      w = 16'($urandom);
      if (w[15:12] == 4'hF && $urandom_range(19, 0) != 0) w[15:12] = 4'hE;
      mem[i] = w;
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    model_reset();

    // LDI / ST / HALT
    clear_mem();
    mem[0] = 16'h0123; mem[1] = 16'h2010; mem[2] = 16'hF000;
    do_reset();
    run_prog(10);
    check("prog1.halted", {15'd0, m_halted}, 16'd1);

    // ADD carry into JC
    clear_mem();
    mem[0] = 16'h0001; mem[1] = 16'h3020; mem[2] = 16'hA005; mem[5] = 16'hF000;
    mem[16'h20] = 16'hFFFF;
    do_reset();
    run_prog(10);

    // LDH / SUB / JZ / SHR
    clear_mem();
    mem[0] = 16'h0034; mem[1] = 16'hD012; mem[2] = 16'h4030; mem[3] = 16'h9100;
    mem[16'h30] = 16'h1234;
    mem[16'h100] = 16'h0001; mem[16'h101] = 16'hC000; mem[16'h102] = 16'hF000;
    do_reset();
    run_prog(10);

    // Reset while in DATA T1, then restart from address 0 with A cleared
    clear_mem();
    mem[0] = 16'h0055; mem[1] = 16'h1020; mem[2] = 16'hF000; mem[16'h20] = 16'hBEEF;
    do_reset();
    run_instr(1'b0);
    run_instr(1'b1);
    do_reset();
    run_prog(10);

    // Randomized programs, last one with heavy stalling
    for (int r = 0; r < 5; r++) begin
      stall_pct = (r == 4) ? 50 : 10;
      clear_mem();
      random_mem();
      do_reset();
      run_prog(150);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
